if_fetch_stage: RTL and testbench

- Instruction-fetch stage: owns the program counter, fetches from instruction memory over a req/ack handshake, and presents {PC+4, Instruction} to the IF/ID pipeline register.
- Handles pipeline freeze from hazard detection and branch redirects from later stages.
- Inserts NOP bubbles while a fetch is outstanding.
- The downstream register samples every cycle, so the outputs themselves encode bubbles.

---
 rtl/if_fetch_stage.sv | 116 +++++++++++
 tb/tb_if_fetch_stage.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | if_fetch_stage : PC owner, req/ack instruction fetch, IF/ID presentation  |
// | Optional: define IF_MISALIGN_CHECK_EN to add misalign_err and aligning.   |
// | Rev 1.0                                                                    |
// +--------------------------------------------------------------------------+
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        Branch_taken,
  input  logic [31:0] Branch_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PC,
  output logic [31:0] Instruction,
  output logic        valid
`ifdef IF_MISALIGN_CHECK_EN
  ,
  output logic        misalign_err
`endif
);

  typedef enum logic [0:0] {
    S_REQ = 1'b0,
    S_OUT = 1'b1
  } state_t;

  state_t      r_state;
  logic [31:0] r_fetch_addr;
  logic        r_redirect_pending;
  logic [31:0] r_redirect_addr;
  logic [31:0] w_target;
  logic [31:0] w_fetch_next;

`ifdef IF_MISALIGN_CHECK_EN
  logic w_misaligned;
  assign w_misaligned = (Branch_addr[1:0] != 2'b00);
  assign w_target     = {Branch_addr[31:2], 2'b00};
`else
  assign w_target     = Branch_addr;
`endif

  assign w_fetch_next = r_fetch_addr + 32'd4;

  // Request drops during the reset cycle so an abandoned fetch is not re-issued.
  assign imem_req  = rst && (r_state == S_REQ);
  assign imem_addr = r_fetch_addr;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state            <= S_REQ;
      r_fetch_addr       <= RESET_PC;
      r_redirect_pending <= 1'b0;
      r_redirect_addr    <= 32'd0;
      PC                 <= 32'd0;
      Instruction        <= NOP_INSTR;
      valid              <= 1'b0;
`ifdef IF_MISALIGN_CHECK_EN
      misalign_err       <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_REQ: begin
          if (Branch_taken) begin
            // Address must stay stable until ack, so an unacked redirect is parked.
            if (imem_ack) begin
              r_fetch_addr       <= w_target;
              r_redirect_pending <= 1'b0;
            end else begin
              r_redirect_pending <= 1'b1;
              r_redirect_addr    <= w_target;
            end
`ifdef IF_MISALIGN_CHECK_EN
            if (w_misaligned) misalign_err <= 1'b1;
`endif
          end else if (imem_ack) begin
            if (r_redirect_pending) begin
              r_fetch_addr       <= r_redirect_addr;
              r_redirect_pending <= 1'b0;
            end else begin
              Instruction  <= imem_rdata;
              PC           <= w_fetch_next;
              r_fetch_addr <= w_fetch_next;
              valid        <= 1'b1;
              r_state      <= S_OUT;
            end
          end
        end
        S_OUT: begin
          if (Branch_taken) begin
            valid        <= 1'b0;
            Instruction  <= NOP_INSTR;
            r_fetch_addr <= w_target;
            r_state      <= S_REQ;
`ifdef IF_MISALIGN_CHECK_EN
            if (w_misaligned) misalign_err <= 1'b1;
`endif
          end else if (!freeze) begin
            valid       <= 1'b0;
            Instruction <= NOP_INSTR;
            r_state     <= S_REQ;
          end
        end
        default: r_state <= S_REQ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_stage.sv
`default_nettype none
// Randomized + directed bench for if_fetch_stage against a cycle-level reference model.
module tb_if_fetch_stage;

  localparam logic [31:0] C_RESET_PC = 32'h0000_0100;
  localparam logic [31:0] C_NOP      = 32'h0000_0013;
  localparam logic [31:0] C_KEY      = 32'hA5A5_A5A5;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        freeze = 1'b0;
  logic        Branch_taken = 1'b0;
  logic [31:0] Branch_addr = 32'd0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic [31:0] PC;
  logic [31:0] Instruction;
  logic        valid;
`ifdef IF_MISALIGN_CHECK_EN
  logic        misalign_err;
`endif

  if_fetch_stage #(
    .RESET_PC  (C_RESET_PC),
    .NOP_INSTR (C_NOP)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .freeze       (freeze),
    .Branch_taken (Branch_taken),
    .Branch_addr  (Branch_addr),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .PC           (PC),
    .Instruction  (Instruction),
    .valid        (valid)
`ifdef IF_MISALIGN_CHECK_EN
    ,
    .misalign_err (misalign_err)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: "waiting" means a fetch is outstanding; "next" is the address being fetched.
  bit          m_known = 1'b0;
  bit          m_waiting;
  logic [31:0] m_next;
  bit          m_has_redirect;
  logic [31:0] m_redirect;
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  bit          m_valid;
  bit          m_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input logic r, input logic f, input logic b,
                     input logic [31:0] ba, input logic ack_en);
    logic [31:0] tgt;
    bit          mis;
    rst = r; freeze = f; Branch_taken = b; Branch_addr = ba;
    #1;
    imem_ack   = ack_en & imem_req;
    imem_rdata = imem_addr ^ C_KEY;
    @(negedge clk);
    if (m_known) begin
      check("imem_req",    {31'd0, imem_req}, {31'd0, (rst && m_waiting)});
      check("imem_addr",   imem_addr, m_next);
      check("PC",          PC, m_pc);
      check("Instruction", Instruction, m_instr);
      check("valid",       {31'd0, valid}, {31'd0, m_valid});
`ifdef IF_MISALIGN_CHECK_EN
      check("misalign_err", {31'd0, misalign_err}, {31'd0, m_err});
`endif
    end
    @(posedge clk);
`ifdef IF_MISALIGN_CHECK_EN
    tgt = {ba[31:2], 2'b00};
    mis = (ba[1:0] != 2'b00);
`else
    tgt = ba;
    mis = 1'b0;
`endif
    if (!r) begin
      m_waiting = 1; m_next = C_RESET_PC; m_has_redirect = 0;
      m_pc = 32'd0; m_instr = C_NOP; m_valid = 0; m_err = 0;
    end else if (m_waiting) begin
      if (b) begin
        m_err = m_err | mis;
        if (imem_ack) begin
          m_next = tgt; m_has_redirect = 0;
        end else begin
          m_has_redirect = 1; m_redirect = tgt;
        end
      end else if (imem_ack && m_has_redirect) begin
        m_next = m_redirect; m_has_redirect = 0;
      end else if (imem_ack) begin
        m_instr = imem_rdata; m_pc = m_next + 32'd4; m_next = m_next + 32'd4;
        m_valid = 1; m_waiting = 0;
      end
    end else begin
      if (b) begin
        m_err = m_err | mis;
        m_valid = 0; m_instr = C_NOP; m_next = tgt; m_waiting = 1;
      end else if (!f) begin
        m_valid = 0; m_instr = C_NOP; m_waiting = 1;
      end
    end
    m_known = 1'b1;
    #1;
  endtask

  initial begin
    logic [31:0] ba;
    // Reset and zero-wait streaming
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    check("lit reset valid", {31'd0, valid}, 32'd0);
    check("lit reset PC", PC, 32'd0);
    check("lit reset instr", Instruction, C_NOP);
    check("lit reset addr", imem_addr, 32'h100);
    check("lit reset req", {31'd0, imem_req}, 32'd0);
    cyc(1, 0, 0, 0, 1);
    check("lit pc0", PC, 32'h104);
    check("lit instr0", Instruction, 32'hA5A5_A4A5);
    check("lit valid0", {31'd0, valid}, 32'd1);
    cyc(1, 0, 0, 0, 1);
    check("lit bubble valid", {31'd0, valid}, 32'd0);
    check("lit bubble addr", imem_addr, 32'h104);
    cyc(1, 0, 0, 0, 1);
    check("lit pc1", PC, 32'h108);
    cyc(1, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 1);
    check("lit pc2", PC, 32'h10C);
    // Delayed ack
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 0, 0, 0);
      check("lit wait addr", imem_addr, 32'h10C);
      check("lit wait valid", {31'd0, valid}, 32'd0);
    end
    cyc(1, 0, 0, 0, 1);
    check("lit pc3", PC, 32'h110);
    // Freeze holds presented instruction
    for (int i = 0; i < 5; i++) begin
      cyc(1, 1, 0, 0, 1);
      check("lit frz pc", PC, 32'h110);
      check("lit frz valid", {31'd0, valid}, 32'd1);
    end
    cyc(1, 0, 0, 0, 0);
    check("lit unfrz valid", {31'd0, valid}, 32'd0);
    check("lit unfrz addr", imem_addr, 32'h110);
    // Redirect during outstanding fetch
    cyc(1, 0, 1, 32'h200, 0);
    check("lit pend addr", imem_addr, 32'h110);
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 1);
    check("lit drop valid", {31'd0, valid}, 32'd0);
    check("lit redirect addr", imem_addr, 32'h200);
    cyc(1, 0, 0, 0, 1);
    check("lit pc redir", PC, 32'h204);
    // Branch beats freeze in S_OUT
    cyc(1, 1, 1, 32'h300, 0);
    check("lit brfrz valid", {31'd0, valid}, 32'd0);
    check("lit brfrz addr", imem_addr, 32'h300);
    // Wrap at top of address space
    cyc(1, 0, 1, 32'hFFFF_FFFC, 1);
    cyc(1, 0, 0, 0, 1);
    check("lit wrap pc", PC, 32'h0);
    check("lit wrap instr", Instruction, 32'h5A5A_5A59);
    check("lit wrap addr", imem_addr, 32'h0);
`ifdef IF_MISALIGN_CHECK_EN
    cyc(1, 0, 1, 32'h203, 0);
    check("lit mis addr", imem_addr, 32'h200);
    check("lit mis err", {31'd0, misalign_err}, 32'd1);
    cyc(1, 0, 0, 0, 1);
    check("lit mis sticky", {31'd0, misalign_err}, 32'd1);
    cyc(0, 0, 0, 0, 0);
    check("lit mis clr", {31'd0, misalign_err}, 32'd0);
`endif
    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      ba = $urandom;
      if ($urandom_range(0, 3) != 0) ba[1:0] = 2'b00;
      if ($urandom_range(0, 7) == 0) ba = 32'hFFFF_FFFC;
      cyc(($urandom_range(0, 79) != 0),
          ($urandom_range(0, 2) == 0),
          ($urandom_range(0, 7) == 0),
          ba,
          ($urandom_range(0, 1) == 0));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
